clk_monitor: RTL

Clock-activity monitor that runs on `mclk` and observes a divided or externally generated clock (`clk_in`), such as the slow clock produced by the board's clock divider. It converts edges into single-cycle ticks, measures period and high time in `mclk` cycles, and reports lock and loss-of-clock status. Miner control logic in the `mclk` domain uses it to qualify hashing-core clocks before starting work.

---
 rtl/clk_monitor.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/clk_monitor.sv
// Clock-activity monitor: synchronizes clk_in into the mclk domain, emits edge
// ticks, measures period/high time in mclk cycles and reports lock / loss.
module clk_monitor #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT     = 1000
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic             clk_in,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARMED  = 3'd1;
    localparam logic [2:0] ST_TRACK  = 3'd2;
    localparam logic [2:0] ST_LOCKED = 3'd3;
    localparam logic [2:0] ST_LOST   = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   p_q;
    logic                   s, rise, fall;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0]       last_q, last_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [CNT_W-1:0]       high_q, high_d;
    logic [2:0]             state_q, state_d;
    logic                   pv_q, pv_d;
    logic                   rise_tick_q, fall_tick_q, locked_q, timeout_q;
    logic                   expired, measuring;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~p_q;
    assign fall = ~s & p_q;

    // cnt+1 saturates so a stalled counter reports all-ones instead of wrapping
    assign cnt_inc   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
    assign expired   = (cnt_q == CNT_TO) & ~rise;
    assign measuring = (state_q == ST_ARMED) || (state_q == ST_TRACK) ||
                       (state_q == ST_LOCKED);

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        period_d = period_q;
        high_d   = high_q;
        pv_d     = 1'b0;
        cnt_d    = rise ? '0 : cnt_inc;

        case (state_q)
            ST_IDLE: begin
                if (rise)         state_d = ST_ARMED;
                else if (expired) state_d = ST_LOST;
            end
            ST_ARMED: begin
                if (rise) begin
                    pv_d     = 1'b1;
                    period_d = cnt_inc;
                    last_d   = cnt_inc;
                    state_d  = ST_TRACK;
                end else if (expired) begin
                    state_d = ST_LOST;
                end
            end
            ST_TRACK: begin
                if (rise) begin
                    pv_d     = 1'b1;
                    period_d = cnt_inc;
                    last_d   = cnt_inc;
                    state_d  = (cnt_inc == last_q) ? ST_LOCKED : ST_TRACK;
                end else if (expired) begin
                    state_d = ST_LOST;
                end
            end
            ST_LOCKED: begin
                if (rise) begin
                    pv_d     = 1'b1;
                    period_d = cnt_inc;
                    if (cnt_inc != last_q) begin
                        state_d = ST_TRACK;
                        last_d  = cnt_inc;
                    end
                end else if (expired) begin
                    state_d = ST_LOST;
                end
            end
            ST_LOST: begin
                if (rise) state_d = ST_ARMED;
            end
            default: state_d = ST_IDLE;
        endcase

        if (fall && measuring) high_d = cnt_inc;
    end

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            sync_q      <= '0;
            p_q         <= 1'b0;
            cnt_q       <= '0;
            last_q      <= '0;
            period_q    <= '0;
            high_q      <= '0;
            state_q     <= ST_IDLE;
            pv_q        <= 1'b0;
            rise_tick_q <= 1'b0;
            fall_tick_q <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], clk_in};
            p_q         <= s;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            period_q    <= period_d;
            high_q      <= high_d;
            state_q     <= state_d;
            pv_q        <= pv_d;
            rise_tick_q <= rise;
            fall_tick_q <= fall;
            locked_q    <= (state_d == ST_LOCKED);
            timeout_q   <= (state_d == ST_LOST);
        end
    end

    assign rise_tick    = rise_tick_q;
    assign fall_tick    = fall_tick_q;
    assign period       = period_q;
    assign high_time    = high_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

endmodule
